l2_ptw_walker: RTL and testbench
================================

Name: l2_ptw_walker

Overview:
- Page-table-walk responder serving the L1 TLB's miss requests.
- On a miss it walks a 3-level Sv39-style page table over a single-outstanding memory port.
- It returns the final PTE, the level at which the walk ended, and a fault flag to the TLB.
- It sits between the L1 TLB miss path and the L2 data port.

Parameters:
- PPN_BITS, 20, physical page number width; physical address width = PPN_BITS+12.
- VPN_BITS, 27, virtual page number width; fixed at 3 levels x 9 bits.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- io_ptbr_ppn  in  PPN_BITS  root page-table PPN; sampled at request accept.
- io_flush  in  1  sfence; aborts the walk in progress.
- io_req_valid  in  1  TLB miss request valid.
- io_req_ready  out  1  walker idle, can accept a request.
- io_req_bits_vpn  in  VPN_BITS  missing VPN.
- io_mem_req_valid  out  1  PTE read request.
- io_mem_req_ready  in  1  memory accepts the read.
- io_mem_req_addr  out  PPN_BITS+12  PTE byte address.
- io_mem_resp_valid  in  1  PTE read data valid; one cycle per accepted read.
- io_mem_resp_data  in  64  PTE.
- io_resp_valid  out  1  walk result valid.
- io_resp_ready  in  1  TLB consumes the result.
- io_resp_bits_pte  out  64  final PTE, or zero on fault.
- io_resp_bits_level  out  2  step index (0..2) at which the walk ended.
- io_resp_bits_error  out  1  page fault.

Behaviour:

State machine:
- States IDLE, REQ, WAIT, DONE. Reset forces IDLE, and all outputs deassert to 0.
- All handshakes complete on clk rising edge when valid & ready.

IDLE:
- io_req_ready=1.
- On accept: latch vpn; ppn_r<=io_ptbr_ppn; lvl<=0; go to REQ.
- A request presented together with io_flush is still accepted; the flush is ignored in IDLE.

REQ:
- io_mem_req_valid=1.
- io_mem_req_addr = {ppn_r, vpn[26-9*lvl -: 9], 3'b000}.
- Address, valid and state are stable until io_mem_req_ready.
- On handshake: go to WAIT.
- io_flush while in REQ without the handshake: go to IDLE; mem_req_valid may drop.
- Flush and handshake in the same cycle: the read is considered issued, so go to WAIT with kill set.

WAIT:
- Wait for io_mem_resp_valid, then decode the PTE.
- PTE fields: V=d[0], R=d[1], W=d[2], X=d[3], ppn=d[PPN_BITS+9:10].
- invalid = !V | (W & !R).
- pointer = V & !R & !W & !X.
- Leaf, ppn aligned: V & (R|X).
- Misaligned superpage is a fault: a leaf at lvl 0 with ppn[17:0]!=0, or a leaf at lvl 1 with ppn[8:0]!=0.
- pointer & lvl<2: ppn_r<=ppn; lvl<=lvl+1; go to REQ.
- pointer at lvl 2: fault.
- Leaf: latch pte=d, error=0; go to DONE.
- Fault: pte=0, error=1; go to DONE.
- If kill was set or io_flush is asserted: discard the PTE, clear kill, go to IDLE with no response.
- io_flush in WAIT before resp_valid sets kill.

DONE:
- io_resp_valid=1; pte, level and error are held stable.
- On io_resp_ready: go to IDLE.
- io_flush in DONE: drop the response and go to IDLE the next cycle. If resp_ready is high in the same cycle, the handshake counts.

Latency and throughput:
- Minimum latency from request accept to resp_valid = 1 + 3*(1+mem latency) cycles for a 3-level walk.
- At most one walk and one memory read outstanding at any time.
- lvl never exceeds 2; there is no wrap-around.
- A new request can be accepted the cycle after the response handshake, because IDLE is registered.

Test Plan:
- 3-level walk: ptbr=0x00100; vpn=0x0000401; memory returns pointers ppn 0x00200 and 0x00300, then leaf 0x0000000012340000|0xCF.
  Required: mem addrs 0x00100000, 0x00200010, 0x00300008; resp pte=0x00000000123400CF, level=2, error=0.
- Gigapage: leaf at step 0 with ppn=0x40000 and RWX set -> level=0, error=0.
  Same leaf with ppn=0x40001 -> error=1, pte=0.
- Faults:
  - Step-1 PTE=0x0 (V=0) -> level=1, error=1.
  - Step-0 PTE with W=1, R=0 -> error=1.
  - Pointer at step 2 -> level=2, error=1.
- Backpressure:
  - mem_req_ready low for 5 cycles: addr and valid are held constant, with exactly one read issued per level.
  - resp_ready low for 4 cycles: resp fields are held and io_req_ready stays 0.
- Flush:
  - Flush in REQ -> IDLE next cycle, no response.
  - Flush during WAIT -> the incoming mem_resp is swallowed and no resp_valid is raised.
  - Flush in DONE -> resp_valid drops.
  - A following request completes normally.
- Reset mid-walk: assert reset in WAIT.
  Required: all outputs are 0 immediately (asynchronous); after release, io_req_ready=1, and a stray mem_resp_valid is ignored in IDLE.

Source files
------------

// File: rtl/l2_ptw_walker.sv
`default_nettype none
// ============================================================================
// Module      : l2_ptw_walker
// Description : Page-table walker serving L1 TLB misses. Walks a 3-level
//               Sv39-style table (9 VPN bits per level) with a single
//               outstanding PTE read. Returns the final PTE, the step index
//               where the walk ended and a page-fault flag.
// Ports       : clk, reset (async, active-high)
//               io_ptbr_ppn         - root table PPN, sampled at accept
//               io_flush            - sfence, aborts the walk in progress
//               io_req_*            - miss request from the TLB (vpn)
//               io_mem_req_*        - PTE read request (byte address)
//               io_mem_resp_*       - PTE read data, one beat per read
//               io_resp_*           - walk result (pte, level, error)
// Revision    : 1.0 - initial release
// ============================================================================
module l2_ptw_walker #(
    parameter int PPN_BITS = 20,
    parameter int VPN_BITS = 27
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PPN_BITS-1:0]   io_ptbr_ppn,
    input  logic                  io_flush,
    input  logic                  io_req_valid,
    output logic                  io_req_ready,
    input  logic [VPN_BITS-1:0]   io_req_bits_vpn,
    output logic                  io_mem_req_valid,
    input  logic                  io_mem_req_ready,
    output logic [PPN_BITS+11:0]  io_mem_req_addr,
    input  logic                  io_mem_resp_valid,
    input  logic [63:0]           io_mem_resp_data,
    output logic                  io_resp_valid,
    input  logic                  io_resp_ready,
    output logic [63:0]           io_resp_bits_pte,
    output logic [1:0]            io_resp_bits_level,
    output logic                  io_resp_bits_error
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]          r_state, w_state_nxt;
    logic [VPN_BITS-1:0] r_vpn, w_vpn_nxt;
    logic [PPN_BITS-1:0] r_ppn, w_ppn_nxt;
    logic [1:0]          r_lvl, w_lvl_nxt;
    logic                r_kill, w_kill_nxt;
    logic [63:0]         r_pte, w_pte_nxt;
    logic                r_error, w_error_nxt;

    logic [8:0]          w_idx;
    logic [PPN_BITS-1:0] w_pte_ppn;
    logic                w_v, w_r, w_w, w_x;
    logic                w_invalid, w_pointer, w_leaf, w_misaligned, w_fault;

    // VPN slice for the current step: step 0 uses the top 9 bits.
    always_comb begin
        case (r_lvl)
            2'd0:    w_idx = r_vpn[26:18];
            2'd1:    w_idx = r_vpn[17:9];
            default: w_idx = r_vpn[8:0];
        endcase
    end

    // PTE decode of the incoming read data.
    assign w_v       = io_mem_resp_data[0];
    assign w_r       = io_mem_resp_data[1];
    assign w_w       = io_mem_resp_data[2];
    assign w_x       = io_mem_resp_data[3];
    assign w_pte_ppn = io_mem_resp_data[PPN_BITS+9:10];

    assign w_invalid    = !w_v || (w_w && !w_r);
    assign w_pointer    = w_v && !w_r && !w_w && !w_x;
    assign w_leaf       = w_v && (w_r || w_x);
    // Superpage leaves must have the low PPN bits covered by the VPN clear.
    assign w_misaligned = ((r_lvl == 2'd0) && (w_pte_ppn[17:0] != 18'd0)) ||
                          ((r_lvl == 2'd1) && (w_pte_ppn[8:0]  != 9'd0));
    assign w_fault      = w_invalid ||
                          (w_pointer && (r_lvl == 2'd2)) ||
                          (w_leaf && w_misaligned);

    always_comb begin
        w_state_nxt = r_state;
        w_vpn_nxt   = r_vpn;
        w_ppn_nxt   = r_ppn;
        w_lvl_nxt   = r_lvl;
        w_kill_nxt  = r_kill;
        w_pte_nxt   = r_pte;
        w_error_nxt = r_error;
        case (r_state)
            c_IDLE: begin
                // Flush is meaningless with no walk in flight, so it is ignored.
                if (io_req_valid) begin
                    w_vpn_nxt   = io_req_bits_vpn;
                    w_ppn_nxt   = io_ptbr_ppn;
                    w_lvl_nxt   = 2'd0;
                    w_kill_nxt  = 1'b0;
                    w_state_nxt = c_REQ;
                end
            end
            c_REQ: begin
                if (io_mem_req_ready) begin
                    // A read that is issued must have its response consumed,
                    // so a concurrent flush only marks it for discard.
                    w_kill_nxt  = io_flush;
                    w_state_nxt = c_WAIT;
                end else if (io_flush) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_WAIT: begin
                if (io_mem_resp_valid) begin
                    if (r_kill || io_flush) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = c_IDLE;
                    end else if (w_fault) begin
                        w_pte_nxt   = 64'd0;
                        w_error_nxt = 1'b1;
                        w_state_nxt = c_DONE;
                    end else if (w_pointer) begin
                        w_ppn_nxt   = w_pte_ppn;
                        w_lvl_nxt   = r_lvl + 2'd1;
                        w_state_nxt = c_REQ;
                    end else begin
                        w_pte_nxt   = io_mem_resp_data;
                        w_error_nxt = 1'b0;
                        w_state_nxt = c_DONE;
                    end
                end else if (io_flush) begin
                    w_kill_nxt = 1'b1;
                end
            end
            default: begin
                if (io_resp_ready || io_flush) begin
                    w_state_nxt = c_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_vpn   <= '0;
            r_ppn   <= '0;
            r_lvl   <= 2'd0;
            r_kill  <= 1'b0;
            r_pte   <= 64'd0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vpn   <= w_vpn_nxt;
            r_ppn   <= w_ppn_nxt;
            r_lvl   <= w_lvl_nxt;
            r_kill  <= w_kill_nxt;
            r_pte   <= w_pte_nxt;
            r_error <= w_error_nxt;
        end
    end

    // Ready is gated by reset so every output reads zero while reset is held.
    assign io_req_ready       = (r_state == c_IDLE) && !reset;
    assign io_mem_req_valid   = (r_state == c_REQ);
    assign io_mem_req_addr    = (r_state == c_REQ) ? {r_ppn, w_idx, 3'b000} : '0;
    assign io_resp_valid      = (r_state == c_DONE);
    assign io_resp_bits_pte   = r_pte;
    assign io_resp_bits_level = r_lvl;
    assign io_resp_bits_error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_l2_ptw_walker.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_ptw_walker
// Description : Directed self-checking bench for l2_ptw_walker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_ptw_walker;

    logic        clk;
    logic        reset;
    logic [19:0] io_ptbr_ppn;
    logic        io_flush;
    logic        io_req_valid;
    logic        io_req_ready;
    logic [26:0] io_req_bits_vpn;
    logic        io_mem_req_valid;
    logic        io_mem_req_ready;
    logic [31:0] io_mem_req_addr;
    logic        io_mem_resp_valid;
    logic [63:0] io_mem_resp_data;
    logic        io_resp_valid;
    logic        io_resp_ready;
    logic [63:0] io_resp_bits_pte;
    logic [1:0]  io_resp_bits_level;
    logic        io_resp_bits_error;

    int total = 0;
    int bad   = 0;
    int rd_count = 0;

    l2_ptw_walker #(.PPN_BITS(20), .VPN_BITS(27)) dut (
        .clk                (clk),
        .reset              (reset),
        .io_ptbr_ppn        (io_ptbr_ppn),
        .io_flush           (io_flush),
        .io_req_valid       (io_req_valid),
        .io_req_ready       (io_req_ready),
        .io_req_bits_vpn    (io_req_bits_vpn),
        .io_mem_req_valid   (io_mem_req_valid),
        .io_mem_req_ready   (io_mem_req_ready),
        .io_mem_req_addr    (io_mem_req_addr),
        .io_mem_resp_valid  (io_mem_resp_valid),
        .io_mem_resp_data   (io_mem_resp_data),
        .io_resp_valid      (io_resp_valid),
        .io_resp_ready      (io_resp_ready),
        .io_resp_bits_pte   (io_resp_bits_pte),
        .io_resp_bits_level (io_resp_bits_level),
        .io_resp_bits_error (io_resp_bits_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (io_mem_req_valid && io_mem_req_ready) rd_count <= rd_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [19:0] ptbr, input logic [26:0] vpn);
        int n;
        n = 0;
        while (!io_req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!io_req_ready) begin
            total++; bad++;
            $display("FAIL req_ready_timeout got=%0b want=1", io_req_ready);
        end
        io_ptbr_ppn     = ptbr;
        io_req_bits_vpn = vpn;
        io_req_valid    = 1'b1;
        tick();
        io_req_valid    = 1'b0;
    endtask

    task automatic wait_mem_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (io_mem_req_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL mem_req_timeout got=%0b want=1", io_mem_req_valid);
        end
    endtask

    // Accepts one read immediately and returns its data the following cycle.
    task automatic mem_serve(input logic [63:0] data, output logic [31:0] addr);
        bit ok;
        wait_mem_req(ok);
        addr = io_mem_req_addr;
        if (!ok) return;
        io_mem_req_ready = 1'b1;
        tick();
        io_mem_req_ready  = 1'b0;
        io_mem_resp_valid = 1'b1;
        io_mem_resp_data  = data;
        tick();
        io_mem_resp_valid = 1'b0;
    endtask

    task automatic wait_resp();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (io_resp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL resp_timeout got=%0b want=1", io_resp_valid);
        end
    endtask

    task automatic consume();
        io_resp_ready = 1'b1;
        tick();
        io_resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total++;
        if (io_req_ready !== 1'b0) begin
            bad++; $display("FAIL reset_hold_req_ready got=%0b want=0", io_req_ready);
        end
        tick(); tick();
        reset = 1'b0;
        tick();
        total++;
        if (io_req_ready !== 1'b1 || io_mem_req_valid !== 1'b0 || io_resp_valid !== 1'b0 ||
            io_resp_bits_pte !== 64'd0 || io_resp_bits_level !== 2'd0 || io_resp_bits_error !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got rdy=%0b mv=%0b rv=%0b pte=%h lvl=%0d err=%0b want 1 0 0 0 0 0",
                     io_req_ready, io_mem_req_valid, io_resp_valid, io_resp_bits_pte,
                     io_resp_bits_level, io_resp_bits_error);
        end
    endtask

    task automatic test_walk3();
        logic [31:0] a0, a1, a2;
        do_req(20'h00100, 27'h0000401);
        mem_serve(64'h0000_0000_0008_0001, a0);
        mem_serve(64'h0000_0000_000C_0001, a1);
        mem_serve(64'h0000_0000_1234_00CF, a2);
        wait_resp();
        total++;
        if (a0 !== 32'h00100000) begin bad++; $display("FAIL walk3_addr0 got=%h want=00100000", a0); end
        total++;
        if (a1 !== 32'h00200010) begin bad++; $display("FAIL walk3_addr1 got=%h want=00200010", a1); end
        total++;
        if (a2 !== 32'h00300008) begin bad++; $display("FAIL walk3_addr2 got=%h want=00300008", a2); end
        total++;
        if (io_resp_bits_pte !== 64'h00000000123400CF || io_resp_bits_level !== 2'd2 ||
            io_resp_bits_error !== 1'b0) begin
            bad++;
            $display("FAIL walk3_resp got pte=%h lvl=%0d err=%0b want 123400cf 2 0",
                     io_resp_bits_pte, io_resp_bits_level, io_resp_bits_error);
        end
        consume();
        total++;
        if (io_resp_valid !== 1'b0 || io_req_ready !== 1'b1) begin
            bad++; $display("FAIL walk3_after got rv=%0b rdy=%0b want 0 1", io_resp_valid, io_req_ready);
        end
    endtask

    task automatic test_gigapage();
        logic [31:0] a0;
        do_req(20'h00123, 27'h0);
        mem_serve(64'h0000_0000_1000_000F, a0);
        wait_resp();
        total++;
        if (a0 !== 32'h00123000 || io_resp_bits_pte !== 64'h000000001000000F ||
            io_resp_bits_level !== 2'd0 || io_resp_bits_error !== 1'b0) begin
            bad++;
            $display("FAIL giga_ok got a=%h pte=%h lvl=%0d err=%0b want 00123000 1000000f 0 0",
                     a0, io_resp_bits_pte, io_resp_bits_level, io_resp_bits_error);
        end
        consume();
        do_req(20'h00123, 27'h0);
        mem_serve(64'h0000_0000_1000_040F, a0);
        wait_resp();
        total++;
        if (io_resp_bits_pte !== 64'd0 || io_resp_bits_level !== 2'd0 || io_resp_bits_error !== 1'b1) begin
            bad++;
            $display("FAIL giga_misaligned got pte=%h lvl=%0d err=%0b want 0 0 1",
                     io_resp_bits_pte, io_resp_bits_level, io_resp_bits_error);
        end
        consume();
    endtask

    task automatic test_faults();
        logic [31:0] a;
        do_req(20'h00100, 27'h0000401);
        mem_serve(64'h0000_0000_0008_0001, a);
        mem_serve(64'h0, a);
        wait_resp();
        total++;
        if (io_resp_bits_pte !== 64'd0 || io_resp_bits_level !== 2'd1 || io_resp_bits_error !== 1'b1) begin
            bad++;
            $display("FAIL fault_invalid got pte=%h lvl=%0d err=%0b want 0 1 1",
                     io_resp_bits_pte, io_resp_bits_level, io_resp_bits_error);
        end
        consume();
        do_req(20'h00100, 27'h0000401);
        mem_serve(64'h0000_0000_0000_0005, a);
        wait_resp();
        total++;
        if (io_resp_bits_pte !== 64'd0 || io_resp_bits_level !== 2'd0 || io_resp_bits_error !== 1'b1) begin
            bad++;
            $display("FAIL fault_w_no_r got pte=%h lvl=%0d err=%0b want 0 0 1",
                     io_resp_bits_pte, io_resp_bits_level, io_resp_bits_error);
        end
        consume();
        do_req(20'h00100, 27'h0000401);
        mem_serve(64'h0000_0000_0008_0001, a);
        mem_serve(64'h0000_0000_000C_0001, a);
        mem_serve(64'h0000_0000_0000_0001, a);
        wait_resp();
        total++;
        if (io_resp_bits_pte !== 64'd0 || io_resp_bits_level !== 2'd2 || io_resp_bits_error !== 1'b1) begin
            bad++;
            $display("FAIL fault_ptr_lvl2 got pte=%h lvl=%0d err=%0b want 0 2 1",
                     io_resp_bits_pte, io_resp_bits_level, io_resp_bits_error);
        end
        consume();
    endtask

    task automatic test_mem_backpressure();
        logic [63:0] data [3];
        logic [31:0] want [3];
        logic [31:0] a;
        bit          ok;
        int          start;
        int          errs;
        data[0] = 64'h80001; data[1] = 64'hC0001; data[2] = 64'h123400CF;
        want[0] = 32'h00100000; want[1] = 32'h00200010; want[2] = 32'h00300008;
        start = rd_count;
        errs  = 0;
        do_req(20'h00100, 27'h0000401);
        for (int l = 0; l < 3; l++) begin
            wait_mem_req(ok);
            a = io_mem_req_addr;
            for (int c = 0; c < 5; c++) begin
                tick();
                if (io_mem_req_valid !== 1'b1 || io_mem_req_addr !== a) errs++;
            end
            total++;
            if (a !== want[l] || errs != 0) begin
                bad++;
                $display("FAIL mem_bp_hold lvl=%0d got addr=%h unstable=%0d want addr=%h unstable=0",
                         l, a, errs, want[l]);
            end
            io_mem_req_ready = 1'b1;
            tick();
            io_mem_req_ready  = 1'b0;
            io_mem_resp_valid = 1'b1;
            io_mem_resp_data  = data[l];
            tick();
            io_mem_resp_valid = 1'b0;
        end
        wait_resp();
        total++;
        if (rd_count - start != 3 || io_resp_bits_pte !== 64'h123400CF) begin
            bad++;
            $display("FAIL mem_bp_reads got reads=%0d pte=%h want 3 123400cf", rd_count - start, io_resp_bits_pte);
        end
        consume();
    endtask

    task automatic test_resp_backpressure();
        logic [31:0] a;
        int          errs;
        errs = 0;
        do_req(20'h00123, 27'h0);
        mem_serve(64'h1000000F, a);
        wait_resp();
        for (int c = 0; c < 4; c++) begin
            if (io_resp_valid !== 1'b1 || io_req_ready !== 1'b0 ||
                io_resp_bits_pte !== 64'h1000000F || io_resp_bits_level !== 2'd0 ||
                io_resp_bits_error !== 1'b0) errs++;
            tick();
        end
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL resp_bp_hold got unstable=%0d want 0", errs);
        end
        consume();
        total++;
        if (io_req_ready !== 1'b1) begin
            bad++; $display("FAIL resp_bp_release got rdy=%0b want 1", io_req_ready);
        end
    endtask

    task automatic test_flush();
        logic [31:0] a;
        bit          ok;
        int          seen;
        // Flush in REQ without handshake.
        do_req(20'h00100, 27'h0000401);
        io_flush = 1'b1;
        tick();
        io_flush = 1'b0;
        total++;
        if (io_req_ready !== 1'b1 || io_mem_req_valid !== 1'b0 || io_resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_req got rdy=%0b mv=%0b rv=%0b want 1 0 0",
                     io_req_ready, io_mem_req_valid, io_resp_valid);
        end
        // Flush while waiting for the read data.
        do_req(20'h00100, 27'h0000401);
        wait_mem_req(ok);
        io_mem_req_ready = 1'b1;
        tick();
        io_mem_req_ready = 1'b0;
        io_flush = 1'b1;
        tick();
        io_flush = 1'b0;
        io_mem_resp_valid = 1'b1;
        io_mem_resp_data  = 64'h1000000F;
        tick();
        io_mem_resp_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (io_resp_valid || io_mem_req_valid) seen++;
            tick();
        end
        total++;
        if (seen != 0 || io_req_ready !== 1'b1) begin
            bad++; $display("FAIL flush_wait got activity=%0d rdy=%0b want 0 1", seen, io_req_ready);
        end
        // Flush in DONE.
        do_req(20'h00123, 27'h0);
        mem_serve(64'h1000000F, a);
        wait_resp();
        io_flush = 1'b1;
        tick();
        io_flush = 1'b0;
        total++;
        if (io_resp_valid !== 1'b0 || io_req_ready !== 1'b1) begin
            bad++; $display("FAIL flush_done got rv=%0b rdy=%0b want 0 1", io_resp_valid, io_req_ready);
        end
        // Following walk completes normally.
        do_req(20'h00100, 27'h0000401);
        mem_serve(64'h80001, a);
        mem_serve(64'hC0001, a);
        mem_serve(64'h123400CF, a);
        wait_resp();
        total++;
        if (a !== 32'h00300008 || io_resp_bits_pte !== 64'h123400CF ||
            io_resp_bits_level !== 2'd2 || io_resp_bits_error !== 1'b0) begin
            bad++;
            $display("FAIL flush_after got a=%h pte=%h lvl=%0d err=%0b want 00300008 123400cf 2 0",
                     a, io_resp_bits_pte, io_resp_bits_level, io_resp_bits_error);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_req(20'h00100, 27'h0000401);
        wait_mem_req(ok);
        io_mem_req_ready = 1'b1;
        tick();
        io_mem_req_ready = 1'b0;
        reset = 1'b1;
        #1;
        total++;
        if (io_req_ready !== 1'b0 || io_mem_req_valid !== 1'b0 || io_mem_req_addr !== 32'd0 ||
            io_resp_valid !== 1'b0 || io_resp_bits_pte !== 64'd0 ||
            io_resp_bits_level !== 2'd0 || io_resp_bits_error !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_outputs got rdy=%0b mv=%0b addr=%h rv=%0b pte=%h lvl=%0d err=%0b want all 0",
                     io_req_ready, io_mem_req_valid, io_mem_req_addr, io_resp_valid,
                     io_resp_bits_pte, io_resp_bits_level, io_resp_bits_error);
        end
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (io_req_ready !== 1'b1) begin
            bad++; $display("FAIL reset_mid_release got rdy=%0b want 1", io_req_ready);
        end
        io_mem_resp_valid = 1'b1;
        io_mem_resp_data  = 64'h1000000F;
        tick();
        io_mem_resp_valid = 1'b0;
        tick();
        total++;
        if (io_resp_valid !== 1'b0 || io_mem_req_valid !== 1'b0 || io_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_stray got rv=%0b mv=%0b rdy=%0b want 0 0 1",
                     io_resp_valid, io_mem_req_valid, io_req_ready);
        end
    endtask

    initial begin
        reset             = 1'b0;
        io_ptbr_ppn       = '0;
        io_flush          = 1'b0;
        io_req_valid      = 1'b0;
        io_req_bits_vpn   = '0;
        io_mem_req_ready  = 1'b0;
        io_mem_resp_valid = 1'b0;
        io_mem_resp_data  = '0;
        io_resp_ready     = 1'b0;
        test_reset();
        test_walk3();
        test_gigapage();
        test_faults();
        test_mem_backpressure();
        test_resp_backpressure();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
